// File: rtl/get_cert_responder_if.sv
// Request/response/ROM bundle for the GET_CERTIFICATE responder.
// The slave modport is the responder; the master modport is whatever drives
// requests, supplies ROM data and consumes responses.
interface get_cert_responder_if #(
    parameter int HDR_W  = 32,
    parameter int PAY_W  = 2048,
    parameter int ADDR_W = 12
);
    // Request side: Enable is a one-cycle strobe, only honoured in IDLE.
    logic              Enable;
    logic [HDR_W-1:0]  header_in;
    logic [PAY_W-1:0]  payload_in;

    // ROM side: rom_data is valid exactly one cycle after rom_rd_en.
    logic              rom_rd_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    // Response side: Ack_out holds until Ack_in is seen.
    logic [HDR_W-1:0]  header;
    logic [PAY_W-1:0]  payload;
    logic [15:0]       rsp_len;
    logic              busy;
    logic              Ack_out;
    logic              Ack_in;

    // FSM state for observation (0=IDLE 1=CHECK 2=FETCH 3=RESP).
    logic [1:0]        state_dbg;

    modport master (
        output Enable, header_in, payload_in, rom_data, Ack_in,
        input  rom_rd_en, rom_addr, header, payload, rsp_len, busy, Ack_out,
               state_dbg
    );

    modport slave (
        input  Enable, header_in, payload_in, rom_data, Ack_in,
        output rom_rd_en, rom_addr, header, payload, rsp_len, busy, Ack_out,
               state_dbg
    );
endinterface

// File: rtl/get_cert_responder.sv
// GET_CERTIFICATE responder: latches one request, validates it, streams the
// requested span of the slot's certificate chain out of a byte-wide ROM and
// presents a CERTIFICATE (or ERROR) response until it is acknowledged.
//
// Handshake: a request is taken when Enable=1 is sampled in IDLE (busy=0);
// Enable at any other time is dropped. A response is offered with Ack_out=1
// and header/payload/rsp_len held stable until Ack_in=1 is sampled; Ack_out
// falls on the next cycle and a new request may be taken from then on.
// Ack_in while Ack_out=0 has no effect.
module get_cert_responder #(
    parameter int          HDR_W      = 32,
    parameter int          PAY_W      = 2048,
    parameter int          ADDR_W     = 12,
    parameter int          SLOT0_BASE = 0,
    parameter int          SLOT1_BASE = 1024,
    parameter int          SLOT2_BASE = 2048,
    parameter logic [15:0] SLOT0_LEN  = 16'd900,
    parameter logic [15:0] SLOT1_LEN  = 16'd600,
    parameter logic [15:0] SLOT2_LEN  = 16'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    get_cert_responder_if.slave  bus
);

    localparam int BYTES = PAY_W / 8;
    localparam int IDX_W = $clog2(BYTES);
    localparam int CNT_W = IDX_W + 1;
    localparam int PB_W  = $clog2(PAY_W);

    localparam logic [7:0] SPDM_VER     = 8'h01;
    localparam logic [7:0] REQ_GET_CERT = 8'h82;
    localparam logic [7:0] RSP_CERT     = 8'h02;
    localparam logic [7:0] RSP_ERROR    = 8'h7F;
    localparam logic [7:0] ERR_UNSUP    = 8'h02;
    localparam logic [7:0] ERR_INVALID  = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FETCH = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_q;

    // Latched request.
    logic [HDR_W-1:0]   req_hdr_q;
    logic [15:0]        req_off_q;
    logic [15:0]        req_len_q;

    // Fetch bookkeeping.
    logic [CNT_W-1:0]   n_q;          // bytes to return
    logic [CNT_W-1:0]   issue_cnt_q;  // ROM reads issued so far
    logic [IDX_W-1:0]   cap_idx_q;    // next payload byte to fill
    logic               rd_pend_q;    // a ROM byte lands this cycle

    // Registered outputs.
    logic               rom_rd_en_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [HDR_W-1:0]   header_q;
    logic [PAY_W-1:0]   payload_q;
    logic [15:0]        rsp_len_q;
    logic               busy_q;
    logic               ack_q;

    // Results of the CHECK-state evaluation.
    logic [7:0]         slot;
    logic [15:0]        slot_len;
    logic [ADDR_W-1:0]  slot_base;
    logic [16:0]        remain17;
    logic [16:0]        n17;
    logic [CNT_W-1:0]   n_d;
    logic               err_d;
    logic [7:0]         code_d;
    logic [ADDR_W-1:0]  addr0_d;
    logic [PB_W-1:0]    cap_msb;

    // Slot lookup, validation in priority order and span length clipping.
    always_comb begin
        slot      = req_hdr_q[HDR_W-17 -: 8];
        slot_len  = 16'd0;
        slot_base = '0;
        case (slot)
            8'd0: begin slot_len = SLOT0_LEN; slot_base = ADDR_W'(SLOT0_BASE); end
            8'd1: begin slot_len = SLOT1_LEN; slot_base = ADDR_W'(SLOT1_BASE); end
            8'd2: begin slot_len = SLOT2_LEN; slot_base = ADDR_W'(SLOT2_BASE); end
            default: begin slot_len = 16'd0; slot_base = '0; end
        endcase

        // 17-bit arithmetic: remain only matters when offset < slot_len.
        remain17 = {1'b0, slot_len} - {1'b0, req_off_q};
        n17      = {1'b0, req_len_q};
        if (n17 > 17'(BYTES)) begin
            n17 = 17'(BYTES);
        end
        if (remain17 < n17) begin
            n17 = remain17;
        end
        n_d = CNT_W'(n17);

        err_d  = 1'b0;
        code_d = ERR_INVALID;
        if (req_hdr_q[HDR_W-1 -: 8] != SPDM_VER) begin
            err_d  = 1'b1;
            code_d = ERR_UNSUP;
        end else if (req_hdr_q[HDR_W-9 -: 8] != REQ_GET_CERT) begin
            err_d = 1'b1;
        end else if ((slot > 8'd2) || (slot_len == 16'd0)) begin
            err_d = 1'b1;
        end else if (req_len_q == 16'd0) begin
            err_d = 1'b1;
        end else if (req_off_q >= slot_len) begin
            err_d = 1'b1;
        end

        addr0_d = slot_base + ADDR_W'(req_off_q);

        // MSB-first byte placement: byte i occupies [PAY_W-1-8i -: 8].
        cap_msb = PB_W'(PAY_W - 1) - PB_W'({cap_idx_q, 3'b000});
    end

    // Main FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_hdr_q   <= '0;
            req_off_q   <= 16'd0;
            req_len_q   <= 16'd0;
            n_q         <= '0;
            issue_cnt_q <= '0;
            cap_idx_q   <= '0;
            rd_pend_q   <= 1'b0;
            rom_rd_en_q <= 1'b0;
            rom_addr_q  <= '0;
            header_q    <= '0;
            payload_q   <= '0;
            rsp_len_q   <= 16'd0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.Enable) begin
                        req_hdr_q <= bus.header_in;
                        req_off_q <= bus.payload_in[PAY_W-1 -: 16];
                        req_len_q <= bus.payload_in[PAY_W-17 -: 16];
                        busy_q    <= 1'b1;
                        state_q   <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (err_d) begin
                        header_q  <= HDR_W'({SPDM_VER, RSP_ERROR, code_d, 8'h00});
                        payload_q <= '0;
                        rsp_len_q <= 16'd0;
                        ack_q     <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        // First read goes out on entry to FETCH.
                        n_q         <= n_d;
                        rom_rd_en_q <= 1'b1;
                        rom_addr_q  <= addr0_d;
                        issue_cnt_q <= CNT_W'(1);
                        cap_idx_q   <= '0;
                        rd_pend_q   <= 1'b0;
                        state_q     <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // Issue side: back-to-back reads until N are out.
                    rd_pend_q <= rom_rd_en_q;
                    if (issue_cnt_q < n_q) begin
                        rom_rd_en_q <= 1'b1;
                        rom_addr_q  <= rom_addr_q + ADDR_W'(1);
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                    end else begin
                        rom_rd_en_q <= 1'b0;
                        rom_addr_q  <= '0;
                    end

                    // Capture side: one cycle behind the issue side.
                    if (rd_pend_q) begin
                        payload_q[cap_msb -: 8] <= bus.rom_data;
                        cap_idx_q <= cap_idx_q + IDX_W'(1);
                        if ({1'b0, cap_idx_q} == (n_q - CNT_W'(1))) begin
                            header_q  <= HDR_W'({SPDM_VER, RSP_CERT, slot, 8'h00});
                            rsp_len_q <= 16'(n_q);
                            ack_q     <= 1'b1;
                            state_q   <= ST_RESP;
                        end
                    end
                end

                ST_RESP: begin
                    if (bus.Ack_in) begin
                        ack_q     <= 1'b0;
                        header_q  <= '0;
                        payload_q <= '0;
                        rsp_len_q <= 16'd0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Drive the bundle from the registers.
    assign bus.rom_rd_en = rom_rd_en_q;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.header    = header_q;
    assign bus.payload   = payload_q;
    assign bus.rsp_len   = rsp_len_q;
    assign bus.busy      = busy_q;
    assign bus.Ack_out   = ack_q;
    assign bus.state_dbg = state_q;

    // Request fields that carry no meaning for this exchange (param2 and the
    // payload tail beyond offset/length).
    logic unused_ok;
    assign unused_ok = ^{req_hdr_q[HDR_W-25:0], bus.payload_in[PAY_W-33:0]};

endmodule
